fd_latch: RTL and testbench
===========================

# fd_latch

Decode-side receiver of the fetch stage: registers the instruction returned by imem for the fetch PC, plus the fetch incremented PC, into the F/D pipeline latch. Generates `should_stall_decode` back to fetch from load-use hazards and a multiply/divide busy state machine. Flushes the latch to a NOP on a taken jump. Sits between fetch and decode in the five-stage pipeline.

## Interface
Parameters:
- MULTDIV_TIMEOUT, 40: maximum cycles spent in BUSY before forced release.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- q_imem  in  32  instruction read from imem at fetch's current PC.
- incremented_pc  in  32  fetch PC + 1.
- should_jump  in  1  taken jump/branch resolved downstream; flushes the latch.
- key_interrupt  in  1  holds the latch (fetch holds PC on the same signal).
- d_x_instructions_output  in  32  instruction currently in the D/X latch.
- multdiv_ready  in  1  multdiv unit result valid (one-cycle pulse).
- f_d_instructions_output  out  32  latched instruction.
- f_d_pc_output  out  32  latched incremented PC.
- f_d_valid  out  1  latch holds a real (non-flushed) instruction.
- should_stall_decode  out  1  combinational stall request to fetch.
- multdiv_timeout  out  1  sticky flag: a BUSY period hit MULTDIV_TIMEOUT.

## Operation
- Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]. NOP = 32'h0.
- Latch update priority: reset > should_jump (load NOP, pc 0, valid 0) > hold (should_stall_decode or key_interrupt: keep contents) > load (q_imem, incremented_pc, valid 1).
- Load-use hazard: d_x opcode is lw (01000), d_x rd != 0, and d_x rd equals the f_d rs; or equals the f_d rt when f_d opcode is 00000; or equals the f_d rd when f_d opcode is sw (00111), bne (00010), blt (00110) or jr (00100). Hazard is suppressed when f_d_valid = 0.
- mult/div = opcode 00000 with aluop 00110 (mul) or 00111 (div).
- Multdiv FSM states:
  - IDLE: goes to BUSY when d_x holds mult/div; counter cleared.
  - BUSY: counter increments each cycle; goes to DONE on multdiv_ready, or when the counter reaches MULTDIV_TIMEOUT-1 (and sets multdiv_timeout).
  - DONE: one cycle, stall released so the mult/div leaves D/X; always goes to IDLE.
- should_stall_decode = load_use_hazard OR (state == BUSY).
- multdiv_timeout clears only on reset.

## Timing
- Latch latency: 1 cycle from q_imem/incremented_pc to outputs.
- Stall is combinational from the current latch and d_x contents, with no register delay.
- Reset values: instruction 0, pc 0, valid 0, state IDLE, counter 0, multdiv_timeout 0, should_stall_decode 0.
- should_jump during a stall or key_interrupt: the flush wins, and a NOP is loaded on that edge.
- multdiv_ready arriving on the IDLE→BUSY edge is ignored; ready is sampled only in BUSY.
- multdiv_ready and timeout in the same cycle: treated as ready, and the flag is not set.
- A back-to-back mult/div enters D/X at the end of DONE, and IDLE re-enters BUSY on the next cycle.
- Reset asserted mid-BUSY: the FSM returns to IDLE immediately and the stall drops asynchronously.

## Structure
- Shared package: opcode/aluop constants (lw, sw, bne, blt, jr, R-type, mul, div), field bit positions, the NOP value, and the FSM state encoding (IDLE, BUSY, DONE).
- One sub-module, `load_use_detect`: combinational; inputs are the f_d instruction, f_d_valid and the d_x instruction; output is the hazard flag.
- Top level holds the latch registers, the FSM and the 6-bit counter.

## Test plan
- Plain flow: q_imem=32'h0808_0005, incremented_pc=7 → next edge f_d_instructions_output=32'h0808_0005, f_d_pc_output=7, valid=1, stall=0.
- Load-use:
  - Setup: d_x = lw $3 (rd=3); f_d = add with rs=3.
  - Required: stall=1 the same cycle, and the latch holds.
  - Release: d_x becomes a NOP, then stall=0 and the latch loads on the next edge.
- Jump flush: stall active and should_jump=1 → next edge instruction=0, pc=0, valid=0, and the hazard clears.
- Multdiv:
  - d_x=mul → BUSY, stall=1.
  - multdiv_ready after 33 cycles → DONE with stall=0, then IDLE; the flag stays 0.
- Timeout: MULTDIV_TIMEOUT=8 with no ready → stall for 8 BUSY cycles, then DONE; multdiv_timeout=1 until reset.
- Async reset mid-BUSY → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fd_latch_pkg.sv
// Shared definitions for the F/D pipeline latch: instruction field layout,
// opcode/aluop constants, the latch payload and the multdiv FSM encoding.
package fd_latch_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned FIELD_W   = 5;
    localparam int unsigned CNT_W     = 6;

    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned ALUOP_LSB = 2;

    localparam logic [FIELD_W-1:0] OP_RTYPE  = 5'b00000;
    localparam logic [FIELD_W-1:0] OP_LW     = 5'b01000;
    localparam logic [FIELD_W-1:0] OP_SW     = 5'b00111;
    localparam logic [FIELD_W-1:0] OP_BNE    = 5'b00010;
    localparam logic [FIELD_W-1:0] OP_BLT    = 5'b00110;
    localparam logic [FIELD_W-1:0] OP_JR     = 5'b00100;
    localparam logic [FIELD_W-1:0] ALUOP_MUL = 5'b00110;
    localparam logic [FIELD_W-1:0] ALUOP_DIV = 5'b00111;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } fd_entry_t;

    function automatic logic [FIELD_W-1:0] get_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] get_rt(input logic [INSTR_W-1:0] instr);
        return instr[RT_LSB +: FIELD_W];
    endfunction

    function automatic logic is_multdiv(input logic [INSTR_W-1:0] instr);
        logic [FIELD_W-1:0] aluop;
        aluop = instr[ALUOP_LSB +: FIELD_W];
        return (get_op(instr) == OP_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags a load-use hazard between the lw in D/X and the instruction in F/D.
module load_use_detect
    import fd_latch_pkg::*;
(
    input  logic [INSTR_W-1:0] fd_instr_i,
    input  logic               fd_valid_i,
    input  logic [INSTR_W-1:0] dx_instr_i,
    output logic               hazard_o
);

    logic [FIELD_W-1:0] dx_rd;
    logic [FIELD_W-1:0] fd_op;
    logic               rs_hit;
    logic               rt_hit;
    logic               rd_hit;

    assign dx_rd = get_rd(dx_instr_i);
    assign fd_op = get_op(fd_instr_i);

    // rt is only a source for R-type; rd is a source for stores, branches and jr
    always_comb begin
        rs_hit   = (dx_rd == get_rs(fd_instr_i));
        rt_hit   = (fd_op == OP_RTYPE) && (dx_rd == get_rt(fd_instr_i));
        rd_hit   = (fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR}) && (dx_rd == get_rd(fd_instr_i));
        hazard_o = fd_valid_i && (get_op(dx_instr_i) == OP_LW) && (dx_rd != '0)
                   && (rs_hit || rt_hit || rd_hit);
    end

endmodule

// File: rtl/fd_latch.sv
// F/D pipeline latch with load-use and multiply/divide stall generation.
module fd_latch
    import fd_latch_pkg::*;
#(
    parameter int unsigned MULTDIV_TIMEOUT = 40
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] q_imem,
    input  logic [PC_W-1:0]    incremented_pc,
    input  logic               should_jump,
    input  logic               key_interrupt,
    input  logic [INSTR_W-1:0] d_x_instructions_output,
    input  logic               multdiv_ready,
    output logic [INSTR_W-1:0] f_d_instructions_output,
    output logic [PC_W-1:0]    f_d_pc_output,
    output logic               f_d_valid,
    output logic               should_stall_decode,
    output logic               multdiv_timeout
);

    fd_entry_t          fd_q, fd_d;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               load_use_hazard;

    load_use_detect u_load_use_detect (
        .fd_instr_i (fd_q.instr),
        .fd_valid_i (fd_q.valid),
        .dx_instr_i (d_x_instructions_output),
        .hazard_o   (load_use_hazard)
    );

    assign should_stall_decode     = load_use_hazard || (state_q == ST_BUSY);
    assign f_d_instructions_output = fd_q.instr;
    assign f_d_pc_output           = fd_q.pc;
    assign f_d_valid               = fd_q.valid;
    assign multdiv_timeout         = timeout_q;

    // Flush beats hold, hold beats load
    always_comb begin
        fd_d = fd_q;
        if (should_jump) begin
            fd_d = '{instr: NOP, pc: '0, valid: 1'b0};
        end else if (!(should_stall_decode || key_interrupt)) begin
            fd_d = '{instr: q_imem, pc: incremented_pc, valid: 1'b1};
        end
    end

    // Multdiv busy tracking; ready is only honoured once in BUSY and wins over timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (is_multdiv(d_x_instructions_output)) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (multdiv_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(MULTDIV_TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fd_q      <= '{instr: NOP, pc: '0, valid: 1'b0};
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            fd_q      <= fd_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fd_latch.sv
// Bench for fd_latch: directed vector table, multdiv sequences and randomized
// traffic against a behavioural model, on two instances (timeout 40 and 8).
module tb_fd_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] q_imem;
    logic [31:0] incremented_pc;
    logic        should_jump;
    logic        key_interrupt;
    logic [31:0] dx;
    logic        multdiv_ready;

    logic [31:0] a_instr, a_pc, b_instr, b_pc;
    logic        a_valid, a_stall, a_tmo, b_valid, b_stall, b_tmo;

    always #5 clock = ~clock;

    fd_latch #(.MULTDIV_TIMEOUT(40)) dut_a (
        .clock(clock), .reset(reset), .q_imem(q_imem), .incremented_pc(incremented_pc),
        .should_jump(should_jump), .key_interrupt(key_interrupt),
        .d_x_instructions_output(dx), .multdiv_ready(multdiv_ready),
        .f_d_instructions_output(a_instr), .f_d_pc_output(a_pc), .f_d_valid(a_valid),
        .should_stall_decode(a_stall), .multdiv_timeout(a_tmo));

    fd_latch #(.MULTDIV_TIMEOUT(8)) dut_b (
        .clock(clock), .reset(reset), .q_imem(q_imem), .incremented_pc(incremented_pc),
        .should_jump(should_jump), .key_interrupt(key_interrupt),
        .d_x_instructions_output(dx), .multdiv_ready(multdiv_ready),
        .f_d_instructions_output(b_instr), .f_d_pc_output(b_pc), .f_d_valid(b_valid),
        .should_stall_decode(b_stall), .multdiv_timeout(b_tmo));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_instr [2];
    logic [31:0] m_pc    [2];
    bit          m_valid [2];
    bit          m_tmo   [2];
    bit          m_done  [2];
    int          m_busy  [2];   // cycles already spent busy, -1 when not busy

    function automatic int limit(input int k);
        return (k == 0) ? 40 : 8;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] f, input bit v, input logic [31:0] d);
        logic [4:0] rd;
        if (!v) return 1'b0;
        if (d[31:27] != 5'b01000) return 1'b0;
        rd = d[26:22];
        if (rd == 5'd0) return 1'b0;
        if (f[21:17] == rd) return 1'b1;
        if (f[31:27] == 5'd0 && f[16:12] == rd) return 1'b1;
        if ((f[31:27] inside {5'd7, 5'd2, 5'd6, 5'd4}) && f[26:22] == rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_multdiv(input logic [31:0] d);
        return (d[31:27] == 5'd0) && (d[6:2] == 5'd6 || d[6:2] == 5'd7);
    endfunction

    function automatic bit ref_stall(input int k);
        return ref_hazard(m_instr[k], m_valid[k], dx) || (m_busy[k] >= 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_instr[k] = 32'h0; m_pc[k] = 32'h0; m_valid[k] = 1'b0;
            m_tmo[k] = 1'b0; m_done[k] = 1'b0; m_busy[k] = -1;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit s;
            s = ref_stall(k);
            if (should_jump) begin
                m_instr[k] = 32'h0; m_pc[k] = 32'h0; m_valid[k] = 1'b0;
            end else if (!(s || key_interrupt)) begin
                m_instr[k] = q_imem; m_pc[k] = incremented_pc; m_valid[k] = 1'b1;
            end
            if (m_busy[k] >= 0) begin
                if (multdiv_ready) begin
                    m_busy[k] = -1; m_done[k] = 1'b1;
                end else if (m_busy[k] == limit(k) - 1) begin
                    m_busy[k] = -1; m_done[k] = 1'b1; m_tmo[k] = 1'b1;
                end else begin
                    m_busy[k]++;
                end
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (ref_multdiv(dx)) begin
                m_busy[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check_stall_model(input string tag);
        chk({tag, "_stall_a"}, 32'(a_stall), 32'(ref_stall(0)));
        chk({tag, "_stall_b"}, 32'(b_stall), 32'(ref_stall(1)));
    endtask

    task automatic check_state_model(input string tag);
        chk({tag, "_instr_a"}, a_instr, m_instr[0]);
        chk({tag, "_pc_a"},    a_pc,    m_pc[0]);
        chk({tag, "_valid_a"}, 32'(a_valid), 32'(m_valid[0]));
        chk({tag, "_tmo_a"},   32'(a_tmo),   32'(m_tmo[0]));
        chk({tag, "_instr_b"}, b_instr, m_instr[1]);
        chk({tag, "_pc_b"},    b_pc,    m_pc[1]);
        chk({tag, "_valid_b"}, 32'(b_valid), 32'(m_valid[1]));
        chk({tag, "_tmo_b"},   32'(b_tmo),   32'(m_tmo[1]));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] q, pc, dx;
        logic        jump, key;
        logic        exp_stall;
        logic [31:0] exp_instr, exp_pc;
        logic        exp_valid;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] q, input logic [31:0] pc, input logic [31:0] d,
                                input logic jump, input logic key, input logic es,
                                input logic [31:0] ei, input logic [31:0] ep, input logic ev);
        vec_t v;
        v.q = q; v.pc = pc; v.dx = d; v.jump = jump; v.key = key;
        v.exp_stall = es; v.exp_instr = ei; v.exp_pc = ep; v.exp_valid = ev;
        return v;
    endfunction

    localparam logic [31:0] LW3 = 32'h40C0_0000;
    localparam logic [31:0] LW2 = 32'h4080_0000;
    localparam logic [31:0] LW5 = 32'h4140_0000;
    localparam logic [31:0] LW0 = 32'h4000_0000;
    localparam logic [31:0] ADD = 32'h0046_2000;   // rd=1 rs=3 rt=2
    localparam logic [31:0] SW5 = 32'h3940_0000;   // sw with rd=5
    localparam logic [31:0] MUL = 32'h0000_0018;
    localparam logic [31:0] DIV = 32'h0000_001C;

    vec_t tbl [13];

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        logic [4:0]  ops [7];
        ops = '{5'd0, 5'd7, 5'd2, 5'd6, 5'd4, 5'd1, 5'd8};
        v = $urandom;
        v[31:27] = ops[$urandom_range(0, 6)];
        v[26:22] = 5'($urandom_range(0, 7));
        v[21:17] = 5'($urandom_range(0, 7));
        v[16:12] = 5'($urandom_range(0, 7));
        return v;
    endfunction

    function automatic logic [31:0] rand_dx();
        logic [31:0] v;
        int unsigned r;
        r = $urandom_range(0, 9);
        v = rand_instr();
        if (r <= 3) v[31:27] = 5'b01000;
        else if (r == 4) begin
            v[31:27] = 5'd0;
            v[6:2] = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
        end else if (r <= 6) v = 32'h0;
        return v;
    endfunction

    initial begin
        reset = 1'b1; q_imem = '0; incremented_pc = '0; should_jump = 1'b0;
        key_interrupt = 1'b0; dx = '0; multdiv_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_instr", a_instr, 32'h0);
        chk("rst_pc", a_pc, 32'h0);
        chk("rst_valid", 32'(a_valid), 32'h0);
        chk("rst_stall", 32'(a_stall), 32'h0);
        chk("rst_tmo", 32'(b_tmo), 32'h0);
        reset = 1'b0;

        tbl[0]  = mk(32'h0808_0005, 32'd7,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0808_0005, 32'd7,  1'b1);
        tbl[1]  = mk(ADD,           32'd8,  32'h0, 1'b0, 1'b0, 1'b0, ADD,           32'd8,  1'b1);
        tbl[2]  = mk(32'h0800_0000, 32'd9,  LW3,   1'b0, 1'b0, 1'b1, ADD,           32'd8,  1'b1);
        tbl[3]  = mk(ADD,           32'd9,  32'h0, 1'b0, 1'b0, 1'b0, ADD,           32'd9,  1'b1);
        tbl[4]  = mk(32'h1234_5678, 32'd10, LW3,   1'b1, 1'b0, 1'b1, 32'h0,         32'd0,  1'b0);
        tbl[5]  = mk(ADD,           32'd11, LW3,   1'b0, 1'b0, 1'b0, ADD,           32'd11, 1'b1);
        tbl[6]  = mk(32'h0000_DEAD, 32'd12, 32'h0, 1'b0, 1'b1, 1'b0, ADD,           32'd11, 1'b1);
        tbl[7]  = mk(32'h0000_BEEF, 32'd13, LW2,   1'b0, 1'b0, 1'b1, ADD,           32'd11, 1'b1);
        tbl[8]  = mk(SW5,           32'd13, 32'h0, 1'b0, 1'b0, 1'b0, SW5,           32'd13, 1'b1);
        tbl[9]  = mk(32'h0000_CAFE, 32'd14, LW5,   1'b0, 1'b0, 1'b1, SW5,           32'd13, 1'b1);
        tbl[10] = mk(ADD,           32'd15, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0,  1'b0);
        tbl[11] = mk(32'h0,         32'd16, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'd16, 1'b1);
        tbl[12] = mk(ADD,           32'd17, LW0,   1'b0, 1'b0, 1'b0, ADD,           32'd17, 1'b1);

        foreach (tbl[i]) begin
            q_imem = tbl[i].q; incremented_pc = tbl[i].pc; dx = tbl[i].dx;
            should_jump = tbl[i].jump; key_interrupt = tbl[i].key;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(a_stall), 32'(tbl[i].exp_stall));
            cycle();
            chk($sformatf("vec%0d_instr", i), a_instr, tbl[i].exp_instr);
            chk($sformatf("vec%0d_pc", i),    a_pc,    tbl[i].exp_pc);
            chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(tbl[i].exp_valid));
        end
        should_jump = 1'b0; key_interrupt = 1'b0;

        // mul in D/X: A waits for ready after 33 busy cycles, B times out repeatedly
        dx = MUL; q_imem = 32'h0; incremented_pc = 32'h0;
        #1;
        chk("md_idle_stall", 32'(a_stall), 32'h0);
        cycle();
        for (int i = 0; i < 33; i++) begin
            #1;
            chk($sformatf("md_busy%0d_stall_a", i), 32'(a_stall), 32'h1);
            chk($sformatf("md_busy%0d_stall_b", i), 32'(b_stall), 32'((i % 10) < 8));
            chk($sformatf("md_busy%0d_tmo_b", i),   32'(b_tmo),   32'(i >= 8));
            chk($sformatf("md_busy%0d_tmo_a", i),   32'(a_tmo),   32'h0);
            cycle();
        end
        multdiv_ready = 1'b1;
        #1;
        chk("md_ready_stall", 32'(a_stall), 32'h1);
        cycle();
        multdiv_ready = 1'b0; dx = 32'h0;
        #1;
        chk("md_done_stall", 32'(a_stall), 32'h0);
        chk("md_done_tmo", 32'(a_tmo), 32'h0);
        cycle();
        #1;
        chk("md_idle2_stall", 32'(a_stall), 32'h0);
        check_state_model("md_after");

        // ready on the IDLE->BUSY edge must not end the busy period
        dx = DIV; multdiv_ready = 1'b1;
        #1;
        check_stall_model("entry");
        cycle();
        multdiv_ready = 1'b0;
        #1;
        chk("entry_ready_ignored_a", 32'(a_stall), 32'h1);
        chk("entry_ready_ignored_b", 32'(b_stall), 32'h1);
        repeat (3) begin
            cycle();
            check_stall_model("entry_busy");
        end

        // asynchronous reset while busy
        #2;
        reset = 1'b1;
        #1;
        chk("areset_stall_a", 32'(a_stall), 32'h0);
        chk("areset_valid_a", 32'(a_valid), 32'h0);
        chk("areset_instr_a", a_instr, 32'h0);
        chk("areset_tmo_b",   32'(b_tmo),   32'h0);
        chk("areset_stall_b", 32'(b_stall), 32'h0);
        model_reset();
        dx = 32'h0;
        #1;
        reset = 1'b0;
        cycle();
        check_state_model("post_reset");

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            q_imem         = rand_instr();
            incremented_pc = $urandom;
            dx             = rand_dx();
            should_jump    = ($urandom_range(0, 9) == 0);
            key_interrupt  = ($urandom_range(0, 7) == 0);
            multdiv_ready  = ($urandom_range(0, 11) == 0);
            #1;
            check_stall_model($sformatf("rnd%0d", n));
            cycle();
            check_state_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
